mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Ports SHALL be: clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i_req, d_req  in  1 each  instruction-side / data-side request to own memory; held high for a whole burst.
REQ-004 i_rd, i_wr, d_rd, d_wr  in  1 each  per-side access strobes, meaningful only while that side is granted.
REQ-005 i_addr, d_addr, i_wdata, d_wdata  in  16 each  per-side address / write data.
REQ-006 i_gnt, d_gnt  out  1 each  registered ownership grant.
REQ-007 i_stall, d_stall  out  1 each  access not accepted this cycle.
REQ-008 i_rdata, d_rdata  out  16 each; i_rvalid, d_rvalid  out  1 each  returned read data and its one-cycle valid.
REQ-009 err  out  1  one-cycle pulse on an illegal access.
REQ-010 mem_addr, mem_wdata  out  16; mem_rd, mem_wr  out  1  to the shared memory.
REQ-011 mem_rdata  in  16; mem_stall  in  1  memory cannot accept an access this cycle.

Function
REQ-012 States SHALL be IDLE, OWN_I, OWN_D, DRAIN; i_gnt=1 only in OWN_I, d_gnt=1 only in OWN_D.
REQ-013 IDLE: d_req=1 and i_req=0 -> OWN_D; i_req=1 and d_req=0 -> OWN_I; both -> side not in last_owner; neither -> IDLE.
REQ-014 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to gnt high.
REQ-015 OWN_x: stay while x_req=1; on x_req=0 -> DRAIN if inflight!=0, else IDLE; last_owner SHALL be updated to x on leaving OWN_x.
REQ-016 DRAIN -> IDLE when inflight==0; no grant in DRAIN.
REQ-017 While owner x is granted, mem_addr/mem_wdata/mem_rd/mem_wr SHALL combinationally equal x's signals; otherwise mem_rd=mem_wr=0 and mem_addr=mem_wdata=0.
REQ-018 Access accepted when x_gnt & (x_rd^x_wr) & ~mem_stall; x_stall = ~x_gnt | mem_stall.
REQ-019 x_rd & x_wr both high while granted: err=1 that cycle, mem_rd=mem_wr=0, nothing accepted.
REQ-020 Memory returns read data exactly MEM_LAT=2 cycles after the accept cycle; a 2-stage valid+owner tag pipeline SHALL route mem_rdata to i_rdata or d_rdata with x_rvalid=1 for that one cycle.
REQ-021 x_rdata SHALL hold its last value when x_rvalid=0.
REQ-022 inflight = count of valid tag-pipeline entries (0..2); release of ownership with reads in flight SHALL still deliver them to the original owner.
REQ-023 Writes complete on accept; they do not enter the tag pipeline.
REQ-024 x_req dropping in the same cycle as an accepted access: access SHALL still be forwarded and accepted.
REQ-025 Requests from a non-granted side SHALL be ignored until IDLE.

Reset
REQ-026 On rst: state=IDLE, last_owner=D (so first contention grants I), tag pipeline cleared, gnt=0, rvalid=0, rdata=0, err=0, mem_rd=mem_wr=0.
REQ-027 rst mid-burst SHALL discard in-flight reads: no rvalid in the 2 cycles after rst deasserts.

Structure
REQ-028 Package mem_arb_pkg SHALL hold MEM_LAT=2, the 2-bit state encoding (IDLE=0, OWN_I=1, OWN_D=2, DRAIN=3) and owner encoding (I=0, D=1).
REQ-029 State and last_owner registers SHALL use the codebase dff cell; one sub-module, mem_arb_tagpipe (MEM_LAT-deep valid/owner shift register with inflight count), is natural.

Verification
REQ-030 After rst, i_req=1 at cycle 0 -> i_gnt=1 at cycle 1; i_rd, i_addr=0x0040 -> mem_rd=1, mem_addr=0x0040; mem_rdata=0xBEEF two cycles later -> i_rvalid=1, i_rdata=0xBEEF, d_rvalid=0.
REQ-031 i_req=d_req=1 same cycle after reset -> OWN_I; release I -> OWN_D next arbitration; both again -> OWN_I (round robin).
REQ-032 D issues read 0x1008 then drops d_req next cycle -> DRAIN for 1 cycle, data 0x1234 delivered on d_rdata with d_rvalid, i_gnt stays 0 until IDLE.
REQ-033 Granted D with mem_stall=1 for 3 cycles holding d_wr, d_addr=0x0200, d_wdata=0x5A5A -> d_stall=1 for 3 cycles, exactly one accepted write on cycle 4.
REQ-034 Granted I asserts i_rd=i_wr=1 -> err=1 for that cycle, mem_rd=mem_wr=0.
REQ-035 rst asserted one cycle after an accepted read -> gnt=0, no i_rvalid/d_rvalid in the following 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Cycles from an accepted read to mem_rdata being valid.
  localparam int MEM_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  // One side's access request as seen by the memory mux.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } side_req_t;

endpackage

// File: rtl/dff.sv
// Generic register cell with synchronous active-high reset.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain D flop, reset to RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/mem_arb_tagpipe.sv
// Valid/owner tag shift register tracking reads in flight to memory.
// Stage 0 is the accept cycle itself, so a read accepted this cycle already
// counts as in flight; the last stage lines up with mem_rdata.
module mem_arb_tagpipe
  import mem_arb_pkg::*;
#(
  parameter int STAGES = MEM_LAT,
  localparam int CW    = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          push_owner,
  output logic          out_vld,
  output logic          out_owner,
  output logic [CW-1:0] inflight
);

  logic [STAGES:1] vld_q, own_q;
  logic [STAGES:0] vld_pipe, own_pipe;

  assign vld_pipe = {vld_q, push};
  assign own_pipe = {own_q, push_owner};

  // Shift tags one stage per cycle; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      own_q <= own_pipe[STAGES-1:0];
    end
  end

  // Reads not yet delivered (the delivering stage is excluded).
  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++) inflight += CW'(vld_pipe[k]);
  end

  assign out_vld   = vld_pipe[STAGES];
  assign out_owner = own_pipe[STAGES];

endmodule

// File: rtl/mem_arb.sv
// Round-robin ownership arbiter between instruction and data sides for a
// single shared memory with fixed read latency.
module mem_arb
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        d_req,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] d_addr,
  input  logic [15:0] i_wdata,
  input  logic [15:0] d_wdata,
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        i_stall,
  output logic        d_stall,
  output logic [15:0] i_rdata,
  output logic [15:0] d_rdata,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_e        state, state_nxt;
  owner_e        last_owner, last_owner_nxt;
  logic [1:0]    state_q;
  logic          last_q;
  side_req_t     i_s, d_s, own_s;
  logic          rd_acc, pipe_vld, pipe_owner;
  logic [CW-1:0] inflight;
  logic [15:0]   i_hold, d_hold;

  dff #(.W(2), .RST_VAL(2'd0)) u_state_ff (
    .clk(clk), .rst(rst), .d(state_nxt), .q(state_q));
  dff #(.W(1), .RST_VAL(1'b1)) u_last_ff (
    .clk(clk), .rst(rst), .d(last_owner_nxt), .q(last_q));

  assign state      = state_e'(state_q);
  assign last_owner = owner_e'(last_q);
  assign i_gnt      = (state == OWN_I);
  assign d_gnt      = (state == OWN_D);

  // Ownership transitions; last_owner records who just released.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (i_req && d_req) state_nxt = (last_owner == OWNER_I) ? OWN_D : OWN_I;
        else if (i_req)     state_nxt = OWN_I;
        else if (d_req)     state_nxt = OWN_D;
      end
      OWN_I: if (!i_req) begin
        last_owner_nxt = OWNER_I;
        state_nxt      = (inflight != '0) ? DRAIN : IDLE;
      end
      OWN_D: if (!d_req) begin
        last_owner_nxt = OWNER_D;
        state_nxt      = (inflight != '0) ? DRAIN : IDLE;
      end
      DRAIN: if (inflight == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign i_s = '{rd: i_rd, wr: i_wr, addr: i_addr, wdata: i_wdata};
  assign d_s = '{rd: d_rd, wr: d_wr, addr: d_addr, wdata: d_wdata};

  // Forward the owner's access; everything is zero with no owner.
  always_comb begin
    own_s = '0;
    if (i_gnt)      own_s = i_s;
    else if (d_gnt) own_s = d_s;
  end

  // Simultaneous rd+wr is rejected outright and flagged.
  assign err       = own_s.rd & own_s.wr;
  assign mem_rd    = own_s.rd & ~own_s.wr;
  assign mem_wr    = own_s.wr & ~own_s.rd;
  assign mem_addr  = own_s.addr;
  assign mem_wdata = own_s.wdata;
  assign rd_acc    = mem_rd & ~mem_stall;
  assign i_stall   = ~i_gnt | mem_stall;
  assign d_stall   = ~d_gnt | mem_stall;

  mem_arb_tagpipe #(.STAGES(MEM_LAT)) u_tagpipe (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_acc),
    .push_owner(d_gnt),
    .out_vld   (pipe_vld),
    .out_owner (pipe_owner),
    .inflight  (inflight)
  );

  assign i_rvalid = pipe_vld & (pipe_owner == OWNER_I);
  assign d_rvalid = pipe_vld & (pipe_owner == OWNER_D);

  // Keep the last delivered word per side for the idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      if (i_rvalid) i_hold <= mem_rdata;
      if (d_rvalid) d_hold <= mem_rdata;
    end
  end

  assign i_rdata = i_rvalid ? mem_rdata : i_hold;
  assign d_rdata = d_rvalid ? mem_rdata : d_hold;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: reads push expected {cycle, side, data},
// a negedge monitor pops and compares on every rvalid.
module tb_mem_arb;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 0, d_req = 0, i_rd = 0, i_wr = 0, d_rd = 0, d_wr = 0;
  logic [15:0] i_addr = 0, d_addr = 0, i_wdata = 0, d_wdata = 0;
  logic        i_gnt, d_gnt, i_stall, d_stall, i_rvalid, d_rvalid, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        mem_rd, mem_wr, mem_stall = 0;
  logic [15:0] mem_rdata = 16'hDEAD;

  typedef struct {
    int          due;
    bit          side;   // 0 = I, 1 = D
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  mem_arb dut (
    .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req),
    .i_rd(i_rd), .i_wr(i_wr), .d_rd(d_rd), .d_wr(d_wr),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_stall(i_stall), .d_stall(d_stall),
    .i_rdata(i_rdata), .d_rdata(d_rdata), .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read that the bench expects to be accepted this cycle.
  task automatic exp_read(input bit side, input logic [15:0] data);
    exp_t e;
    e.due  = cyc + 2;
    e.side = side;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Memory model: present the scheduled word in its due cycle.
  always @(posedge clk) begin
    cyc++;
    #1;
    mem_rdata = 16'hDEAD;
    foreach (sb[k]) if (sb[k].due == cyc) mem_rdata = sb[k].data;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (i_rvalid || d_rvalid) begin
      if (sb.size() == 0) chk("spurious_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rvalid_cycle", cyc, e.due);
        chk("rvalid_side", {30'd0, i_rvalid, d_rvalid}, e.side ? 32'd1 : 32'd2);
        chk("rdata", {16'd0, e.side ? d_rdata : i_rdata}, {16'd0, e.data});
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_rvalid", {30'd0, i_rvalid, d_rvalid}, e.side ? 32'd1 : 32'd2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_rdwr", {mem_rd, mem_wr}, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // Basic I read burst, one-cycle grant latency, back-to-back reads
    i_req = 1;
    #1 chk("lat_cyc0_i_gnt", i_gnt, 0);
    tick();
    chk("lat_cyc1_i_gnt", i_gnt, 1);
    chk("lat_cyc1_d_gnt", d_gnt, 0);
    i_rd = 1; i_addr = 16'h0040;
    #1;
    chk("rd_mem_rd", mem_rd, 1);
    chk("rd_mem_addr", mem_addr, 16'h0040);
    chk("rd_i_stall", i_stall, 0);
    exp_read(0, 16'hBEEF);
    tick();
    i_addr = 16'h0042;
    exp_read(0, 16'hC0DE);
    tick();
    i_rd = 0;
    tick();
    tick();
    chk("hold_i_rvalid", i_rvalid, 0);
    chk("hold_i_rdata", i_rdata, 16'hC0DE);
    i_req = 0;
    tick();
    i_addr = 16'h1111; i_wdata = 16'h2222; i_rd = 1;
    #1;
    chk("idle_i_gnt", i_gnt, 0);
    chk("idle_mem_addr", mem_addr, 0);
    chk("idle_mem_wdata", mem_wdata, 0);
    chk("idle_mem_rd", mem_rd, 0);
    i_rd = 0;

    // Round robin after reset: I, then D, then I again
    do_reset();
    i_req = 1; d_req = 1;
    tick();
    chk("rr1_i_gnt", i_gnt, 1);
    chk("rr1_d_gnt", d_gnt, 0);
    i_req = 0;
    tick();
    chk("rr_idle_gnt", {i_gnt, d_gnt}, 0);
    tick();
    chk("rr2_d_gnt", d_gnt, 1);
    d_req = 0;
    tick();
    i_req = 1; d_req = 1;
    tick();
    chk("rr3_i_gnt", i_gnt, 1);
    chk("rr3_d_gnt", d_gnt, 0);
    i_req = 0; d_req = 0;
    tick();

    // D read then release: drain one cycle, I waits for IDLE
    d_req = 1;
    tick();
    chk("drn_d_gnt", d_gnt, 1);
    i_req = 1;
    d_rd = 1; d_addr = 16'h1008;
    #1;
    chk("drn_mem_addr", mem_addr, 16'h1008);
    chk("drn_i_stall", i_stall, 1);
    exp_read(1, 16'h1234);
    tick();
    d_rd = 0; d_req = 0;
    #1 chk("drn_still_d", d_gnt, 1);
    tick();
    chk("drn_no_gnt", {i_gnt, d_gnt}, 0);
    tick();
    chk("drn_idle_i_gnt", i_gnt, 0);
    tick();
    chk("drn_then_i_gnt", i_gnt, 1);
    i_req = 0;
    tick();

    // Stalled D write: three stalled cycles, then exactly one accept
    d_req = 1;
    tick();
    chk("wr_d_gnt", d_gnt, 1);
    d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h5A5A; mem_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wr_stall", d_stall, 1);
      chk("wr_fwd", mem_wr, 1);
      tick();
    end
    mem_stall = 0;
    #1;
    chk("wr_accept_stall", d_stall, 0);
    chk("wr_accept_mem_wr", mem_wr, 1);
    chk("wr_accept_addr", mem_addr, 16'h0200);
    chk("wr_accept_wdata", mem_wdata, 16'h5A5A);
    tick();
    d_wr = 0; d_req = 0;
    #1 chk("wr_done_mem_wr", mem_wr, 0);
    tick();

    // Illegal rd+wr on I
    i_req = 1;
    tick();
    i_rd = 1; i_wr = 1;
    #1;
    chk("ill_err", err, 1);
    chk("ill_mem_rdwr", {mem_rd, mem_wr}, 0);
    tick();
    i_rd = 0; i_wr = 0;
    #1 chk("ill_err_clear", err, 0);

    // Drop request in the same cycle as an accepted read
    i_req = 0; i_rd = 1; i_addr = 16'h0077;
    #1 chk("drop_mem_rd", mem_rd, 1);
    exp_read(0, 16'h7777);
    tick();
    i_rd = 0;
    #1 chk("drop_no_gnt", i_gnt, 0);
    tick();
    tick();
    tick();

    // Reset right after an accepted read discards it
    i_req = 1;
    tick();
    i_rd = 1; i_addr = 16'h0100;
    tick();
    i_rd = 0; i_req = 0; rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid_gnt", {i_gnt, d_gnt}, 0);
      chk("rstmid_rvalid", {i_rvalid, d_rvalid}, 0);
      tick();
    end

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
